// File: rtl/marquee_window.sv
// rtl/marquee_window.sv - scrolling WINDOW-wide viewer over a snapshotted DEPTH-entry segment buffer
module marquee_window #(
    parameter int          DEPTH       = 29,
    parameter int          WINDOW      = 6,
    parameter int          STEP_CYCLES = 32768,
    parameter logic [6:0]  BLANK       = 7'b1111111
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DEPTH-1:0][6:0]          frames,
    input  logic                           load,
    input  logic                           run,
    input  logic                           dir,
    output logic [WINDOW-1:0][6:0]         win,
    output logic [$clog2(DEPTH)-1:0]       offset,
    output logic                           wrap,
    output logic                           loaded
);

    localparam int OW = $clog2(DEPTH);
    localparam int CW = $clog2(STEP_CYCLES);
    localparam logic [OW-1:0] OFF_MAX = OW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_HOLD,
        S_SCROLL
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH-1:0][6:0] buf_q, buf_d;
    logic [OW-1:0]         off_q, off_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  wrap_q, wrap_d;
    logic                  loaded_q, loaded_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_EMPTY;
            buf_q    <= {DEPTH{BLANK}};
            off_q    <= '0;
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            off_q    <= off_d;
            cnt_q    <= cnt_d;
            wrap_q   <= wrap_d;
            loaded_q <= loaded_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        off_d    = off_q;
        cnt_d    = cnt_q;
        wrap_d   = 1'b0;
        loaded_d = loaded_q;
        if (load) begin
            // A snapshot overrides any step due on this edge, so no wrap can fire.
            buf_d    = frames;
            off_d    = '0;
            cnt_d    = '0;
            loaded_d = 1'b1;
            state_d  = run ? S_SCROLL : S_HOLD;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (run) state_d = S_SCROLL;
                end
                S_SCROLL: begin
                    if (!run) begin
                        state_d = S_HOLD;
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_d = '0;
                        if (!dir) begin
                            wrap_d = (off_q == OFF_MAX);
                            off_d  = (off_q == OFF_MAX) ? '0 : off_q + OW'(1);
                        end else begin
                            wrap_d = (off_q == '0);
                            off_d  = (off_q == '0) ? OFF_MAX : off_q - OW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic logic [OW-1:0] win_index(input logic [OW-1:0] base, input int k);
        logic [OW:0] s;
        s = {1'b0, base} + (OW+1)'(k);
        if (s >= (OW+1)'(DEPTH)) s = s - (OW+1)'(DEPTH);
        return s[OW-1:0];
    endfunction

    always_comb begin
        win = '0;
        for (int k = 0; k < WINDOW; k++) begin
            win[k] = (state_q == S_EMPTY) ? BLANK : buf_q[win_index(off_q, k)];
        end
    end

    assign offset = off_q;
    assign wrap   = wrap_q;
    assign loaded = loaded_q;

endmodule
